// File: rtl/syn_mem_pkg.sv
// -----------------------------------------------------------------------------
// syn_mem_pkg
// Shared defaults for the synchronous memory family (syn_dual_ram, syn_fifo,
// syn_fifo_ctrl).
//   DEF_RAM_WIDTH : default data word width
//   DEF_RAM_DEPTH : default number of RAM entries (2**DEF_ADDR_SIZE)
//   DEF_ADDR_SIZE : default RAM address width
//   ptr_t         : FIFO pointer type, one wrap bit above the RAM address
// -----------------------------------------------------------------------------
package syn_mem_pkg;

  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_RAM_DEPTH = 16;
  localparam int DEF_ADDR_SIZE = 4;

  // Extra MSB distinguishes "full" from "empty" when the address bits match.
  typedef logic [DEF_ADDR_SIZE:0] ptr_t;

endpackage

// File: rtl/syn_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// syn_fifo_ctrl
// First-word-fall-through FIFO controller driving one syn_dual_ram. The
// controller owns only pointers and a head-valid flag; every data word lives in
// the RAM, and the RAM read register doubles as the head-of-queue register.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   flush           : synchronous clear of the queue (beats push and pop)
//   push_valid/ready: producer handshake, push_data is the word offered
//   pop_valid/ready : consumer handshake, pop_data is the head word
//   ram_wr_en/ad    : RAM write strobe and address, ram_data_in = push_data
//   ram_rd_en/ad    : RAM read strobe and address, ram_data_out feeds pop_data
//   count           : stored words (RAM entries plus the head word)
//   full, empty, almost_full, almost_empty : status flags
// -----------------------------------------------------------------------------
module syn_fifo_ctrl
  import syn_mem_pkg::*;
#(
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [RAM_WIDTH-1:0] push_data,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [RAM_WIDTH-1:0] pop_data,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_wr_ad,
  output logic [ADDR_SIZE-1:0] ram_rd_ad,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  input  logic [RAM_WIDTH-1:0] ram_data_out,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam logic [ADDR_SIZE:0] PTR_ZERO = {(ADDR_SIZE+1){1'b0}};
  localparam logic [ADDR_SIZE:0] PTR_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0] DEPTH_C  = (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_C  = (ADDR_SIZE+1)'(AFULL_LVL);
  localparam logic [ADDR_SIZE:0] AEMPTY_C = (ADDR_SIZE+1)'(AEMPTY_LVL);

  logic [ADDR_SIZE:0] wr_ptr_r;
  logic [ADDR_SIZE:0] rd_ptr_r;
  logic               out_valid_r;

  logic [ADDR_SIZE:0] ram_cnt_s;
  logic [ADDR_SIZE:0] count_s;
  logic               full_s;
  logic               push_ready_s;
  logic               wr_en_s;
  logic               rd_en_s;

  // Occupancy, handshakes and RAM strobes from registered state plus live inputs.
  always_comb begin
    // Modulo subtraction handles pointer wrap; the MSB separates full from empty.
    ram_cnt_s    = wr_ptr_r - rd_ptr_r;
    full_s       = (ram_cnt_s == DEPTH_C);
    // No write-through: a pop in the same cycle never frees a slot for a push.
    push_ready_s = !full_s && !flush;
    wr_en_s      = push_valid && push_ready_s;
    // Prefetch into the head register whenever it is empty or being drained.
    // ram_cnt_s comes from registered pointers, so a read never targets the
    // slot being written on the same edge.
    if (flush) begin
      rd_en_s = 1'b0;
    end else if ((ram_cnt_s != PTR_ZERO) && (!out_valid_r || pop_ready)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    count_s = ram_cnt_s + {{ADDR_SIZE{1'b0}}, out_valid_r};
  end

  // Pointer and head-valid state; flush clears the queue without RAM access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      out_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      // Head stays valid until consumed, or is refilled by this cycle's read.
      out_valid_r <= rd_en_s || (out_valid_r && !pop_ready);
    end
  end

  assign push_ready   = push_ready_s;
  assign pop_valid    = out_valid_r;
  // The RAM holds its output while ram_rd_en is low, so the head stays stable.
  assign pop_data     = ram_data_out;
  assign ram_wr_en    = wr_en_s;
  assign ram_rd_en    = rd_en_s;
  assign ram_wr_ad    = wr_ptr_r[ADDR_SIZE-1:0];
  assign ram_rd_ad    = rd_ptr_r[ADDR_SIZE-1:0];
  assign ram_data_in  = push_data;
  assign count        = count_s;
  assign full         = full_s;
  assign empty        = !out_valid_r;
  assign almost_full  = (count_s >= AFULL_C);
  assign almost_empty = (count_s <= AEMPTY_C);

endmodule

// File: tb/tb_syn_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_syn_fifo_ctrl
// Drives syn_fifo_ctrl next to a behavioural dual-port RAM and compares every
// output against a queue model. Each queued word remembers the edge at which
// it was accepted; it can be presented at the head once it sits at the front
// of the queue and at least one further edge has passed.
// -----------------------------------------------------------------------------
module tb_syn_fifo_ctrl;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int A  = 4;
  localparam int AF = 12;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         push_valid;
  logic         push_ready;
  logic [W-1:0] push_data;
  logic         pop_valid;
  logic         pop_ready;
  logic [W-1:0] pop_data;
  logic         ram_wr_en;
  logic         ram_rd_en;
  logic [A-1:0] ram_wr_ad;
  logic [A-1:0] ram_rd_ad;
  logic [W-1:0] ram_data_in;
  logic [W-1:0] ram_data_out;
  logic [A:0]   count;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;

  syn_fifo_ctrl #(
    .RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A),
    .AFULL_LVL(AF), .AEMPTY_LVL(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_wr_ad(ram_wr_ad), .ram_rd_ad(ram_rd_ad),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Behavioural syn_dual_ram: registered read port that holds when not read.
  logic [W-1:0] mem [D];
  logic [W-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_ad] <= ram_data_in;
    if (ram_rd_en) ram_q <= mem[ram_rd_ad];
  end
  assign ram_data_out = ram_q;

  typedef struct {
    logic [W-1:0] data;
    int           edge_no;
  } ent_t;

  ent_t q[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit head_vis();
    return (q.size() > 0) && (q[0].edge_no < edge_n);
  endfunction

  // One clock cycle: apply inputs, check all outputs against the model,
  // take the edge, update the model. Entered and left at a falling edge.
  task automatic step(input logic pv, input logic [W-1:0] pd, input logic pr, input logic fl);
    bit hv, fullx, acc, popx;
    int ram_n;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
    #1;
    hv    = head_vis();
    ram_n = q.size() - (hv ? 1 : 0);
    fullx = (ram_n == D);
    acc   = pv && !fullx && !fl;
    popx  = hv && pr && !fl;
    chk("push_ready", 32'(push_ready), 32'(!fullx && !fl));
    chk("pop_valid", 32'(pop_valid), 32'(hv));
    if (hv) chk("pop_data", 32'(pop_data), 32'(q[0].data));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(fullx));
    chk("empty", 32'(empty), 32'(!hv));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("ram_wr_en", 32'(ram_wr_en), 32'(acc));
    chk("ram_rd_en", 32'(ram_rd_en), 32'((ram_n > 0) && (!hv || pr) && !fl));
    @(posedge clk);
    edge_n++;
    if (fl) begin
      q.delete();
    end else begin
      if (popx) void'(q.pop_front());
      if (acc) q.push_back('{pd, edge_n});
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_push_ready"}, 32'(push_ready), 32'd1);
    chk({tag, "_pop_valid"}, 32'(pop_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_ram_wr_en"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_ram_rd_en"}, 32'(ram_rd_en), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_data  = 8'h00;
    pop_ready  = 1'b0;
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word: appears two edges after acceptance, held while stalled.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_not_yet", 32'(pop_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_valid", 32'(pop_valid), 32'd1);
    chk("a5_data", 32'(pop_data), 32'hA5);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_held", 32'(pop_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to capacity: 16 in RAM plus the head word.
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd17);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_refuse", 32'(push_ready), 32'd0);
    step(1'b1, 8'h55, 1'b1, 1'b0);   // refused even with a pop in the same cycle
    chk("refuse_count", 32'(count), 32'd16);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_count", 32'(count), 32'd0);

    // Streaming through the address wrap, prefilled with three words.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      if (i > 1) chk("stream_count", 32'(count), 32'd3);
      chk("stream_no_bubble", 32'(pop_valid), 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with five queued words, then reuse.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("after_flush_data", 32'(pop_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset with seven words stored.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd7);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    edge_n++;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic pv, pr, fl;
      logic [W-1:0] pd;
      pv = ($urandom_range(0, 3) != 0);
      pr = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 63) == 0);
      pd = 8'($urandom);
      step(pv, pd, pr, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
